// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bip_pkg
//  Purpose  : Shared opcodes, accumulator-mux codes, FSM states and
//             instruction field positions for the BIP control unit.
//  Revision : 1.0 - initial release
// ============================================================================
package bip_pkg;

  // Instruction field positions: {opcode[15:11], operand[10:0]}
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int OPERAND_LSB = 0;

  // Opcodes; every other value is executed as a NOP
  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  // Instruction sequencing states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bip_if.sv
`default_nettype none
// ============================================================================
//  Module   : bip_if
//  Purpose  : Memory / datapath bus of the BIP control unit. The master side
//             is the control unit, the slave side is the memories+datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface bip_if #(
  parameter int NB_DATA            = 16,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_DATA_S_EXT      = 10,
  parameter int NB_SEL_A           = 2
);
  logic                          i_valid;
  logic [NB_DATA-1:0]            i_instruction;
  logic [LOG2_N_INSMEM_ADDR-1:0] o_insmem_addr;
  logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr;
  logic                          o_rd_ram;
  logic                          o_wr_ram;
  logic [NB_DATA_S_EXT-1:0]      o_data_instruction;
  logic [NB_SEL_A-1:0]           o_sel_a;
  logic                          o_sel_b;
  logic                          o_wr_acc;
  logic                          o_op_code;
  logic                          o_halt;

  modport master (
    input  i_valid, i_instruction,
    output o_insmem_addr, o_data_addr, o_rd_ram, o_wr_ram, o_data_instruction,
           o_sel_a, o_sel_b, o_wr_acc, o_op_code, o_halt
  );

  modport slave (
    output i_valid, i_instruction,
    input  o_insmem_addr, o_data_addr, o_rd_ram, o_wr_ram, o_data_instruction,
           o_sel_a, o_sel_b, o_wr_acc, o_op_code, o_halt
  );
endinterface
`default_nettype wire

// File: rtl/bip_pc.sv
`default_nettype none
// ============================================================================
//  Module   : bip_pc
//  Purpose  : Program counter with synchronous reset, increment enable and
//             wrap from the last instruction address back to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module bip_pc #(
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  input  wire logic                          i_inc,
  output logic      [LOG2_N_INSMEM_ADDR-1:0] o_pc
);
  localparam logic [LOG2_N_INSMEM_ADDR-1:0] C_PC_LAST = LOG2_N_INSMEM_ADDR'(N_INSMEM_ADDR - 1);

  logic [LOG2_N_INSMEM_ADDR-1:0] r_pc;

  // PC advances once per decoded instruction, wrapping explicitly at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= (r_pc == C_PC_LAST) ? '0 : r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;
endmodule
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
//  Module   : bip_control
//  Purpose  : BIP CPU control unit: fetches instructions, holds the PC and IR,
//             and sequences the accumulator datapath and data memory.
//  Revision : 1.0 - initial release
// ============================================================================
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int N_INSMEM_ADDR      = 2048,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int NB_DATA_S_EXT      = 10,
  parameter int NB_SEL_A           = 2
) (
  input  wire logic i_clock,
  input  wire logic i_reset,
  bip_if.master     bus
);
  state_t                        r_state;
  state_t                        w_next;
  logic [NB_DATA-1:0]            r_ir;
  logic [NB_OPCODE-1:0]          w_opcode;
  logic [LOG2_N_INSMEM_ADDR-1:0] w_pc;
  logic                          w_pc_inc;
  logic                          w_strobe_en;
  logic                          w_rd, w_wr, w_wacc, w_sel_b, w_op, w_halt;
  logic [NB_SEL_A-1:0]           w_sel_a;
  logic                          w_unused_ir;

  assign w_opcode    = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign w_unused_ir = ^r_ir[NB_OPERAND-1:LOG2_N_DATA_ADDR];
  assign w_pc_inc    = bus.i_valid && (r_state == ST_DECODE);
  // Strobes drop while stalled and during the reset cycle itself
  assign w_strobe_en = bus.i_valid && !i_reset;

  bip_pc #(
    .N_INSMEM_ADDR     (N_INSMEM_ADDR),
    .LOG2_N_INSMEM_ADDR(LOG2_N_INSMEM_ADDR)
  ) u_pc (
    .clk  (i_clock),
    .rst  (i_reset),
    .i_inc(w_pc_inc),
    .o_pc (w_pc)
  );

  // State register; i_valid=0 freezes the sequence
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
    end else if (bus.i_valid) begin
      r_state <= w_next;
    end
  end

  // Instruction register captures memory read data during DECODE
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ir <= '0;
    end else if (w_pc_inc) begin
      r_ir <= bus.i_instruction;
    end
  end

  // Next-state and control decode from registered state and IR only
  always_comb begin
    w_next  = r_state;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_wacc  = 1'b0;
    w_sel_a = SEL_A_MEM;
    w_sel_b = 1'b0;
    w_op    = 1'b0;
    w_halt  = 1'b0;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        w_next = ST_FETCH;
        case (w_opcode)
          OP_LDI: begin
            w_sel_a = SEL_A_IMM;
            w_wacc  = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            w_sel_b = 1'b1;
            w_sel_a = SEL_A_ALU;
            w_op    = (w_opcode == OP_ADDI);
            w_wacc  = 1'b1;
          end
          OP_STO: w_wr = 1'b1;
          OP_LD, OP_ADD, OP_SUB: begin
            w_rd   = 1'b1;
            w_next = ST_MEM;
          end
          OP_HLT:  w_next = ST_HALT;
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        w_next = ST_FETCH;
        w_wacc = 1'b1;
        if (w_opcode != OP_LD) begin
          w_sel_a = SEL_A_ALU;
          w_op    = (w_opcode == OP_ADD);
        end
      end
      ST_HALT: w_halt = 1'b1;
      default: w_next = ST_FETCH;
    endcase
  end

  assign bus.o_insmem_addr      = w_pc;
  assign bus.o_data_addr        = r_ir[LOG2_N_DATA_ADDR-1:0];
  assign bus.o_data_instruction = r_ir[NB_DATA_S_EXT-1:0];
  assign bus.o_rd_ram           = w_rd && w_strobe_en;
  assign bus.o_wr_ram           = w_wr && w_strobe_en;
  assign bus.o_wr_acc           = w_wacc && w_strobe_en;
  assign bus.o_sel_a            = w_sel_a;
  assign bus.o_sel_b            = w_sel_b;
  assign bus.o_op_code          = w_op;
  assign bus.o_halt             = w_halt;
endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bip_control
//  Purpose  : Self-checking bench for bip_control against an instruction-level
//             reference model of the expected per-cycle control outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bip_control;

  typedef struct packed {
    logic [10:0] addr;
    logic        rd, wr, wacc;
    logic [1:0]  sel_a;
    logic        sel_b, op, halt;
    logic        chk_ir;
    logic [9:0]  daddr, imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rom [2048];
  logic [10:0] m_pc;
  int n_checks = 0;
  int n_fail   = 0;

  bip_if bus ();

  bip_control dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory
  always @(posedge clk) bus.i_instruction <= rom[bus.o_insmem_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Phases: 0 fetch, 1 decode, 2 execute, 3 memory, 4 halted
  function automatic exp_t expect_for(input logic [15:0] ins, input int ph, input logic [10:0] pc);
    exp_t e;
    logic [4:0] opc;
    e     = '0;
    opc   = ins[15:11];
    e.addr   = (ph <= 1) ? pc : pc + 11'd1;
    e.daddr  = ins[9:0];
    e.imm    = ins[9:0];
    e.chk_ir = (ph == 2 || ph == 3);
    if (ph == 2) begin
      case (opc)
        5'd1: e.wr = 1'b1;
        5'd2, 5'd4, 5'd6: e.rd = 1'b1;
        5'd3: begin e.sel_a = 2'b01; e.wacc = 1'b1; end
        5'd5: begin e.sel_b = 1'b1; e.sel_a = 2'b10; e.op = 1'b1; e.wacc = 1'b1; end
        5'd7: begin e.sel_b = 1'b1; e.sel_a = 2'b10; e.wacc = 1'b1; end
        default: ;
      endcase
    end else if (ph == 3) begin
      e.wacc = 1'b1;
      if (opc == 5'd4) begin e.sel_a = 2'b10; e.op = 1'b1; end
      if (opc == 5'd6) e.sel_a = 2'b10;
    end else if (ph == 4) begin
      e.halt = 1'b1;
    end
    return e;
  endfunction

  task automatic compare(input exp_t e);
    chk("insmem_addr", 16'(bus.o_insmem_addr), 16'(e.addr));
    chk("rd_ram",      16'(bus.o_rd_ram),      16'(e.rd));
    chk("wr_ram",      16'(bus.o_wr_ram),      16'(e.wr));
    chk("wr_acc",      16'(bus.o_wr_acc),      16'(e.wacc));
    chk("sel_a",       16'(bus.o_sel_a),       16'(e.sel_a));
    chk("sel_b",       16'(bus.o_sel_b),       16'(e.sel_b));
    chk("op_code",     16'(bus.o_op_code),     16'(e.op));
    chk("halt",        16'(bus.o_halt),        16'(e.halt));
    if (e.chk_ir) begin
      chk("data_addr", 16'(bus.o_data_addr),        16'(e.daddr));
      chk("imm",       16'(bus.o_data_instruction), 16'(e.imm));
    end
  endtask

  // One clock: drive valid, check at the falling edge, advance past the rising edge
  task automatic step(input logic valid, input exp_t e);
    exp_t x;
    x = e;
    if (!valid) begin x.rd = 1'b0; x.wr = 1'b0; x.wacc = 1'b0; end
    bus.i_valid = valid;
    @(negedge clk);
    compare(x);
    @(posedge clk);
    #1;
  endtask

  // Execute the instruction at the model PC, checking every cycle
  task automatic run_instr(input int stall_exec, input bit rnd, input bit stop_before_mem);
    logic [15:0] ins;
    logic [4:0]  opc;
    int nph, stalls;
    ins = rom[m_pc];
    opc = ins[15:11];
    nph = (opc == 5'd2 || opc == 5'd4 || opc == 5'd6) ? 4 : 3;
    for (int ph = 0; ph < nph; ph++) begin
      if (stop_before_mem && ph == 3) begin
        m_pc = m_pc + 11'd1;
        return;
      end
      stalls = (ph == 2) ? stall_exec : 0;
      if (rnd) stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat (stalls) step(1'b0, expect_for(ins, ph, m_pc));
      step(1'b1, expect_for(ins, ph, m_pc));
    end
    m_pc = m_pc + 11'd1;
  endtask

  initial begin
    logic [4:0] opc;
    int found;
    bus.i_valid = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
    rom[0] = 16'h1805;   // LDI 5
    rom[1] = 16'h2BFF;   // ADDI -1
    rom[2] = 16'h3802;   // SUBI 2
    rom[3] = 16'h1010;   // LD 0x010
    rom[4] = 16'h0BFF;   // STO 0x3FF
    rom[5] = 16'h2010;   // ADD 0x010 (stalled in execute)
    rom[6] = 16'hF800;   // illegal -> NOP
    rom[7] = 16'h0000;   // HLT

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    step(1'b1, exp_t'(0));
    rst = 1'b0;
    m_pc = '0;

    // Directed program
    repeat (5) run_instr(0, 1'b0, 1'b0);
    run_instr(5, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), expect_for(16'h0000, 4, m_pc - 11'd1));

    // Reset out of HALT
    rst = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, exp_t'(0));

    // Random program spanning the whole address space, with PC wrap
    for (int i = 0; i < 2048; i++) begin
      opc = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
      rom[i] = {opc, 11'($urandom)};
    end
    rom[5] = 16'h1155;   // guarantees a memory-phase instruction after the wrap
    rst = 1'b0;
    m_pc = '0;
    for (int i = 0; i < 2048; i++) run_instr(0, 1'b1, 1'b0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("pc_wrap", 16'(bus.o_insmem_addr), 16'h0000);
    @(posedge clk);
    #1;

    // Reset while an LD/ADD/SUB is in its memory phase
    found = 0;
    for (int i = 0; i < 2048 && found == 0; i++) begin
      opc = rom[m_pc][15:11];
      if (opc == 5'd2 || opc == 5'd4 || opc == 5'd6) found = 1;
      else run_instr(0, 1'b1, 1'b0);
    end
    chk("mem_instr_found", 16'(found), 16'd1);
    run_instr(0, 1'b0, 1'b1);
    rst = 1'b1;
    bus.i_valid = 1'b1;
    @(negedge clk);
    chk("wr_acc_in_reset", 16'(bus.o_wr_acc), 16'd0);
    chk("rd_ram_in_reset", 16'(bus.o_rd_ram), 16'd0);
    @(posedge clk);
    #1;
    step(1'b1, exp_t'(0));
    rst = 1'b0;
    m_pc = '0;
    repeat (4) run_instr(0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
